rgb_capture: RTL
================

RGB_CAPTURE -- requirements
Module: rgb_capture

Interface
REQ-001 SHALL have parameter LOCK_FRAMES, default 3, meaning the number of consecutive matching frame comparisons required to assert locked (legal range 1..7).
REQ-002 SHALL have port Clk9M, input, 1 bit: the pixel clock; every input is sampled on its rising edge.
REQ-003 SHALL have port Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port vs_in, input, 1 bit: vertical sync; low during sync, high otherwise.
REQ-005 SHALL have port hs_in, input, 1 bit: horizontal sync; low during sync, high otherwise; informational only.
REQ-006 SHALL have port de_in, input, 1 bit: data enable; high for active pixels.
REQ-007 SHALL have port rgb_in, input, 16 bits: RGB565 pixel data.
REQ-008 SHALL have port pix_data, output, 16 bits: captured pixel.
REQ-009 SHALL have port pix_x, output, 10 bits: column index of pix_data, 0-based.
REQ-010 SHALL have port pix_y, output, 10 bits: row index of pix_data, 0-based.
REQ-011 SHALL have port pix_valid, output, 1 bit: pix_data, pix_x and pix_y are valid in this cycle.
REQ-012 SHALL have port frame_start, output, 1 bit: one-cycle pulse at the start of each captured frame.
REQ-013 SHALL have port h_active, output, 10 bits: width in pixels of the last completed frame.
REQ-014 SHALL have port v_active, output, 10 bits: height in lines of the last completed frame.
REQ-015 SHALL have port locked, output, 1 bit: the input format is stable.
REQ-016 SHALL have port frame_err, output, 1 bit: the last completed frame was malformed.

Function
REQ-017 SHALL register vs_in, de_in and rgb_in into stage A, and copy stage A vs/de into stage B, on every clock edge.
REQ-018 SHALL detect vs_rise as A.vs=1 and B.vs=0, and de_fall as A.de=0 and B.de=1.
REQ-019 SHALL implement FSM state S_WAIT, held from reset until the first vs_rise; in S_WAIT no pixels are output and no statistics are updated.
REQ-020 SHALL implement FSM state S_FRAME, entered from S_WAIT on vs_rise; it stays in S_FRAME thereafter, and each subsequent vs_rise ends the current frame and begins the next.
REQ-021 SHALL, on every vs_rise, pulse frame_start for exactly one cycle (registered off vs_rise) and clear x_cnt, y_cnt, line_w and err_acc.
REQ-022 SHALL, in S_FRAME with A.vs=1 and A.de=1, output pix_valid=1 on the next edge, with pix_data=A.rgb, pix_x=x_cnt and pix_y=y_cnt; latency from de_in/rgb_in at the pins to pix_valid is 2 clock edges.
REQ-023 SHALL increment x_cnt once per valid pixel; at x_cnt=1023 it saturates, no further pix_valid is generated for that line, and err_acc is set.
REQ-024 SHALL, on de_fall in S_FRAME, store x_cnt into line_w on the first line of a frame; on a later line whose x_cnt differs from line_w it sets err_acc; in either case it then sets x_cnt=0 and y_cnt=y_cnt+1, saturating at 1023 and setting err_acc.
REQ-025 SHALL treat A.de=1 while A.vs=0 as an error: no pix_valid, and err_acc is set.
REQ-026 SHALL, on a vs_rise that ends a frame, load h_active=line_w, v_active=y_cnt and frame_err=err_acc, all in the same cycle.
REQ-027 SHALL maintain a 3-bit match_cnt that is incremented (saturating at LOCK_FRAMES) when a just-ended frame has err_acc=0, y_cnt≠0, a valid previous frame, and (line_w, y_cnt) equal to the previous frame's h_active/v_active; otherwise match_cnt=0.
REQ-028 SHALL drive locked=1 exactly when match_cnt=LOCK_FRAMES, so that locked falls in the same cycle as any mismatch.
REQ-029 SHALL clear the prev_valid flag at reset and set it at each frame end; the first frame end after reset never increments match_cnt.
REQ-030 SHALL, when vs_rise and de activity coincide in stage A, have the frame-start clear take priority over x_cnt/y_cnt increments, while the pixel in that cycle is still output with pix_x=0 and pix_y=0.

Reset
REQ-031 SHALL, with Rst_n low at any time (including mid-frame), immediately drive pix_data=0, pix_x=0, pix_y=0, pix_valid=0, frame_start=0, h_active=0, v_active=0, locked=0 and frame_err=0, clear all counters, stage registers and match_cnt, and set the FSM to S_WAIT.

Verification
REQ-032 SHALL pass this scenario: 480x272 stimulus (525 clocks/line, DE high 480 clocks/line, 286 lines/frame, 272 DE lines) -> per frame, 130560 pix_valid cycles; last pixel pix_x=479, pix_y=271; at the next vs_rise, h_active=480, v_active=272, frame_err=0.
REQ-033 SHALL pass this scenario: reset released mid-frame -> zero pix_valid until the first vs_rise; locked=1 at the vs_rise ending the 4th complete frame (LOCK_FRAMES=3).
REQ-034 SHALL pass this scenario: while locked, line 100 of one frame carries 479 DE pixels -> at that frame's end frame_err=1, locked=0 the same cycle, match_cnt=0; relocks after 3 further clean frames.
REQ-035 SHALL pass this scenario: DE pulsed high for 5 clocks during VS low -> no pix_valid, frame_err=1 at frame end.
REQ-036 SHALL pass this scenario: first pixel of a frame presented in the same cycle as the vs_rise -> that pixel is output with pix_x=0, pix_y=0, and frame_start and pix_valid are both high in the same cycle.
REQ-037 SHALL pass this scenario: Rst_n asserted during pixel 200 of line 50 -> all outputs 0 asynchronously; after release, behaviour matches the mid-frame reset-release scenario (REQ-033).

Source files
------------

// File: rtl/rgb_capture.sv
// rgb_capture: captures RGB565 pixels with x/y coordinates, measures frame geometry,
// flags malformed frames and reports lock once the format repeats LOCK_FRAMES times.
module rgb_capture #(
    parameter int LOCK_FRAMES = 3
) (
    input  logic        Clk9M,
    input  logic        Rst_n,
    input  logic        vs_in,
    input  logic        hs_in,
    input  logic        de_in,
    input  logic [15:0] rgb_in,
    output logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_valid,
    output logic        frame_start,
    output logic [9:0]  h_active,
    output logic [9:0]  v_active,
    output logic        locked,
    output logic        frame_err
);
    localparam logic [0:0] S_WAIT  = 1'b0;
    localparam logic [0:0] S_FRAME = 1'b1;
    localparam logic [2:0] LOCK_N  = 3'(LOCK_FRAMES);
    localparam logic [9:0] CNT_MAX = 10'h3ff;

    logic        a_vs, a_de, b_vs, b_de, a_ok, b_ok;
    logic [15:0] a_rgb;
    logic [0:0]  state;
    logic [9:0]  x_cnt, y_cnt, line_w;
    logic        err_acc, prev_valid;
    logic [2:0]  match_cnt;
    logic        vs_rise, de_fall, in_frame, take_pix, lock_ok;
    logic        unused_hs;

    assign unused_hs = hs_in;
    assign in_frame  = state == S_FRAME;
    // b_ok masks the false edge that stage B's cleared value would create right after reset
    assign vs_rise   = a_vs & ~b_vs & b_ok;
    assign de_fall   = ~a_de & b_de;
    assign take_pix  = a_vs & a_de & (vs_rise | (in_frame & (x_cnt != CNT_MAX)));
    assign lock_ok   = ~err_acc & (y_cnt != '0) & prev_valid & (line_w == h_active) & (y_cnt == v_active);
    assign locked    = match_cnt == LOCK_N;

    always_ff @(posedge Clk9M or negedge Rst_n) begin
        if (!Rst_n) begin
            a_vs        <= 1'b0;
            a_de        <= 1'b0;
            a_rgb       <= '0;
            b_vs        <= 1'b0;
            b_de        <= 1'b0;
            a_ok        <= 1'b0;
            b_ok        <= 1'b0;
            state       <= S_WAIT;
            x_cnt       <= '0;
            y_cnt       <= '0;
            line_w      <= '0;
            err_acc     <= 1'b0;
            prev_valid  <= 1'b0;
            match_cnt   <= '0;
            pix_data    <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            h_active    <= '0;
            v_active    <= '0;
            frame_err   <= 1'b0;
        end else begin
            a_vs        <= vs_in;
            a_de        <= de_in;
            a_rgb       <= rgb_in;
            b_vs        <= a_vs;
            b_de        <= a_de;
            a_ok        <= 1'b1;
            b_ok        <= a_ok;
            frame_start <= vs_rise;
            pix_valid   <= take_pix;
            if (take_pix) begin
                pix_data <= a_rgb;
                pix_x    <= vs_rise ? '0 : x_cnt;
                pix_y    <= vs_rise ? '0 : y_cnt;
            end
            if (vs_rise) begin
                state   <= S_FRAME;
                x_cnt   <= '0;
                y_cnt   <= '0;
                line_w  <= '0;
                err_acc <= 1'b0;
                if (in_frame) begin
                    h_active   <= line_w;
                    v_active   <= y_cnt;
                    frame_err  <= err_acc;
                    prev_valid <= 1'b1;
                    match_cnt  <= lock_ok ? (locked ? match_cnt : match_cnt + 3'd1) : '0;
                end
            end else if (in_frame) begin
                if (a_de & a_vs) begin
                    if (x_cnt == CNT_MAX) err_acc <= 1'b1;
                    else x_cnt <= x_cnt + 10'd1;
                end
                if (a_de & ~a_vs) err_acc <= 1'b1;
                if (de_fall) begin
                    if (y_cnt == '0) line_w <= x_cnt;
                    else if (x_cnt != line_w) err_acc <= 1'b1;
                    x_cnt <= '0;
                    if (y_cnt == CNT_MAX) err_acc <= 1'b1;
                    else y_cnt <= y_cnt + 10'd1;
                end
            end
        end
    end
endmodule
